// File: rtl/bcd_lap_counter_if.sv
// Control and display bundle between the stopwatch controller and the BCD lap counter.
// master drives the count controls; slave is the counter datapath.
interface bcd_lap_counter_if #(
  parameter int N_DIGITS = 6
);
  logic                    tick;
  logic                    up;
  logic                    clear;
  logic                    lap;
  logic [4*N_DIGITS-1:0]   count;
  logic [4*N_DIGITS-1:0]   disp;
  logic                    lap_active;
  logic                    overflow;
  logic                    at_zero;

  modport master (
    output tick, up, clear, lap,
    input  count, disp, lap_active, overflow, at_zero
  );

  modport slave (
    input  tick, up, clear, lap,
    output count, disp, lap_active, overflow, at_zero
  );
endinterface

// File: rtl/bcd_lap_counter.sv
// Multi-digit BCD up/down time counter with per-digit mod-10/mod-6 digits,
// single-cycle carry/borrow ripple, down-count saturation at zero and a lap-hold display.
module bcd_lap_counter #(
  parameter int                  N_DIGITS  = 6,
  parameter logic [N_DIGITS-1:0] MOD6_MASK = 6'b101000
) (
  input logic               clk,
  input logic               rst,
  bcd_lap_counter_if.slave  bus
);
  localparam int W = 4 * N_DIGITS;

  logic [W-1:0] count_q, count_d;
  logic [W-1:0] lap_q, lap_d;
  logic         lap_active_q, lap_active_d;
  logic         overflow_q, overflow_d;

  logic [W-1:0] inc_val, dec_val;
  logic         all_max, all_zero;
  logic         carry, borrow;

  function automatic logic [3:0] digit_max(input int idx);
    return MOD6_MASK[idx] ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] dmax);
    return (d == dmax) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] digit_dec(input logic [3:0] d, input logic [3:0] dmax);
    return (d == 4'd0) ? dmax : d - 4'd1;
  endfunction

  // Carry and borrow both ripple through every digit in the same cycle.
  always_comb begin
    carry   = 1'b1;
    borrow  = 1'b1;
    inc_val = count_q;
    dec_val = count_q;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (carry)
        inc_val[4*i +: 4] = digit_inc(count_q[4*i +: 4], digit_max(i));
      if (borrow)
        dec_val[4*i +: 4] = digit_dec(count_q[4*i +: 4], digit_max(i));
      carry  = carry  & (count_q[4*i +: 4] == digit_max(i));
      borrow = borrow & (count_q[4*i +: 4] == 4'd0);
    end
    all_max  = carry;
    all_zero = borrow;
  end

  always_comb begin
    count_d      = count_q;
    lap_d        = lap_q;
    lap_active_d = lap_active_q;
    overflow_d   = 1'b0;
    if (bus.clear) begin
      count_d      = '0;
      lap_d        = '0;
      lap_active_d = 1'b0;
    end else begin
      if (bus.tick) begin
        if (bus.up) begin
          count_d    = inc_val;
          overflow_d = all_max;
        end else if (!all_zero) begin
          count_d = dec_val;
        end
      end
      // Lap captures the pre-tick value so a concurrent tick does not leak into disp.
      if (bus.lap) begin
        if (!lap_active_q) begin
          lap_d        = count_q;
          lap_active_d = 1'b1;
        end else begin
          lap_active_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      lap_q        <= '0;
      lap_active_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      count_q      <= count_d;
      lap_q        <= lap_d;
      lap_active_q <= lap_active_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.count      = count_q;
  assign bus.disp       = lap_active_q ? lap_q : count_q;
  assign bus.lap_active = lap_active_q;
  assign bus.overflow   = overflow_q;
  assign bus.at_zero    = (count_q == '0);
endmodule
